// File: rtl/floor_color_sequencer.sv
// Floor colour sequencer: drives the top/bottom and middle band colours of
// the three-band floor renderer. Walks a fixed per-level palette with a
// channel-by-channel fade and overrides both bands with a white flash.
// All visible changes land on the edge where frame_start is high.
//
// state | meaning
// IDLE  | colours settled on the palette entry for level
// FADE  | stepping channels toward the palette entry for level
// FLASH | both bands white; previous colours parked in shadow regs
module floor_color_sequencer #(
    parameter int NUM_LEVELS   = 4,
    parameter int FADE_DIV     = 2,
    parameter int FLASH_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        level_up,
    input  logic        flash_req,
    output logic [11:0] topColor,
    output logic [11:0] midColor,
    output logic [1:0]  level,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FADE, FLASH} state_t;

    localparam logic [3:0] DIV_LOAD   = 4'(FADE_DIV - 1);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_FRAMES - 1);
    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [11:0] WHITE     = 12'hFFF;

    function automatic logic [11:0] pal_top(input logic [1:0] idx);
        case (idx)
            2'd0:    return 12'h00F;
            2'd1:    return 12'h0A0;
            2'd2:    return 12'hA0A;
            default: return 12'hF80;
        endcase
    endfunction

    function automatic logic [11:0] pal_mid(input logic [1:0] idx);
        case (idx)
            2'd0:    return 12'h888;
            2'd1:    return 12'h444;
            2'd2:    return 12'h666;
            default: return 12'h222;
        endcase
    endfunction

    // One unsigned step of a 4-bit channel toward its target, never wrapping.
    function automatic logic [3:0] step_ch(input logic [3:0] cur, input logic [3:0] tgt);
        if (cur < tgt)
            return cur + 4'd1;
        else if (cur > tgt)
            return cur - 4'd1;
        else
            return cur;
    endfunction

    function automatic logic [11:0] step_color(input logic [11:0] cur, input logic [11:0] tgt);
        return {step_ch(cur[11:8], tgt[11:8]),
                step_ch(cur[7:4],  tgt[7:4]),
                step_ch(cur[3:0],  tgt[3:0])};
    endfunction

    state_t      state, state_next;
    logic [11:0] top_next, mid_next;
    logic [11:0] shadow_top, shadow_mid, shadow_top_next, shadow_mid_next;
    logic [1:0]  level_next;
    logic [3:0]  div_cnt, div_next, flash_cnt, flash_next;
    logic        pend_lvl, pend_flash, pend_lvl_next, pend_flash_next;
    logic        busy_next;
    logic        pl, pf, start_flash;
    logic [11:0] tgt_top, tgt_mid, stepped_top, stepped_mid;

    // Next-state, colour and counter decisions; only frame_start edges move the FSM.
    always_comb begin
        state_next      = state;
        top_next        = topColor;
        mid_next        = midColor;
        shadow_top_next = shadow_top;
        shadow_mid_next = shadow_mid;
        level_next      = level;
        div_next        = div_cnt;
        flash_next      = flash_cnt;
        start_flash     = 1'b0;
        // Requests in the same cycle as frame_start are serviced on that frame.
        pl              = pend_lvl | level_up;
        pf              = pend_flash | flash_req;
        pend_lvl_next   = pl;
        pend_flash_next = pf;
        tgt_top         = pal_top(level);
        tgt_mid         = pal_mid(level);
        stepped_top     = step_color(topColor, tgt_top);
        stepped_mid     = step_color(midColor, tgt_mid);

        if (frame_start) begin
            case (state)
                IDLE: begin
                    if (pf) begin
                        start_flash = 1'b1;
                    end else if (pl) begin
                        level_next    = (level == LAST_LEVEL) ? 2'd0 : level + 2'd1;
                        div_next      = DIV_LOAD;
                        pend_lvl_next = 1'b0;
                        state_next    = FADE;
                    end
                end
                FADE: begin
                    if (pf) begin
                        start_flash = 1'b1;
                    end else if (div_cnt != 4'd0) begin
                        div_next = div_cnt - 4'd1;
                    end else begin
                        div_next = DIV_LOAD;
                        top_next = stepped_top;
                        mid_next = stepped_mid;
                        if (stepped_top == tgt_top && stepped_mid == tgt_mid)
                            state_next = IDLE;
                    end
                end
                FLASH: begin
                    if (pf) begin
                        flash_next      = FLASH_LOAD;
                        pend_flash_next = 1'b0;
                    end else if (flash_cnt != 4'd0) begin
                        flash_next = flash_cnt - 4'd1;
                    end else begin
                        // div_cnt was frozen during the flash, so an interrupted fade picks up where it left off.
                        top_next   = shadow_top;
                        mid_next   = shadow_mid;
                        state_next = (shadow_top != tgt_top || shadow_mid != tgt_mid) ? FADE : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (start_flash) begin
            shadow_top_next = topColor;
            shadow_mid_next = midColor;
            top_next        = WHITE;
            mid_next        = WHITE;
            flash_next      = FLASH_LOAD;
            pend_flash_next = 1'b0;
            state_next      = FLASH;
        end

        busy_next = (state_next != IDLE);
    end

    // State, output and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            topColor   <= 12'h00F;
            midColor   <= 12'h888;
            shadow_top <= 12'h000;
            shadow_mid <= 12'h000;
            level      <= 2'd0;
            div_cnt    <= 4'd0;
            flash_cnt  <= 4'd0;
            pend_lvl   <= 1'b0;
            pend_flash <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            topColor   <= top_next;
            midColor   <= mid_next;
            shadow_top <= shadow_top_next;
            shadow_mid <= shadow_mid_next;
            level      <= level_next;
            div_cnt    <= div_next;
            flash_cnt  <= flash_next;
            pend_lvl   <= pend_lvl_next;
            pend_flash <= pend_flash_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_floor_color_sequencer.sv
// Testbench for floor_color_sequencer: directed steps followed by random
// traffic, every cycle compared against a frame-level reference model.
module tb_floor_color_sequencer;

    localparam int NUM_LEVELS   = 4;
    localparam int FADE_DIV     = 2;
    localparam int FLASH_FRAMES = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        level_up = 1'b0;
    logic        flash_req = 1'b0;
    logic [11:0] topColor, midColor;
    logic [1:0]  level;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    floor_color_sequencer #(
        .NUM_LEVELS(NUM_LEVELS), .FADE_DIV(FADE_DIV), .FLASH_FRAMES(FLASH_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .level_up(level_up),
        .flash_req(flash_req), .topColor(topColor), .midColor(midColor),
        .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: six channel values {Rt,Gt,Bt,Rm,Gm,Bm} plus frame-level bookkeeping.
    int cur[6];
    int saved[6];
    int m_level, white_left, wait_left;
    bit m_white, m_fading, want_lvl, want_flash;

    function automatic int pal(int lvl, int k);
        int p;
        case (lvl)
            0:       p = 'h00F888;
            1:       p = 'h0A0444;
            2:       p = 'hA0A666;
            default: p = 'hF80222;
        endcase
        return (p >> (20 - 4 * k)) & 15;
    endfunction

    function automatic bit at_target();
        for (int k = 0; k < 6; k++)
            if (cur[k] != pal(m_level, k)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit fs, input bit lu, input bit fr, input bit rs);
        if (rs) begin
            for (int k = 0; k < 6; k++) cur[k] = pal(0, k);
            m_level = 0; m_white = 0; m_fading = 0;
            want_lvl = 0; want_flash = 0; white_left = 0; wait_left = 0;
            return;
        end
        want_lvl   = want_lvl | lu;
        want_flash = want_flash | fr;
        if (!fs) return;
        if (m_white) begin
            if (want_flash) begin
                white_left = FLASH_FRAMES - 1;
                want_flash = 0;
            end else if (white_left > 0) begin
                white_left--;
            end else begin
                m_white = 0;
                for (int k = 0; k < 6; k++) cur[k] = saved[k];
                m_fading = !at_target();
            end
        end else if (want_flash) begin
            for (int k = 0; k < 6; k++) begin
                saved[k] = cur[k];
                cur[k]   = 15;
            end
            m_white    = 1;
            white_left = FLASH_FRAMES - 1;
            want_flash = 0;
        end else if (m_fading) begin
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                wait_left = FADE_DIV - 1;
                for (int k = 0; k < 6; k++)
                    cur[k] = cur[k] + (pal(m_level, k) > cur[k] ? 1 : 0) - (pal(m_level, k) < cur[k] ? 1 : 0);
                if (at_target()) m_fading = 0;
            end
        end else if (want_lvl) begin
            m_level   = (m_level + 1) % NUM_LEVELS;
            wait_left = FADE_DIV - 1;
            m_fading  = 1;
            want_lvl  = 0;
        end
    endtask

    function automatic logic [11:0] exp_top();
        return 12'((cur[0] << 8) | (cur[1] << 4) | cur[2]);
    endfunction

    function automatic logic [11:0] exp_mid();
        return 12'((cur[3] << 8) | (cur[4] << 4) | cur[5]);
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("model_top", topColor, exp_top());
        chk("model_mid", midColor, exp_mid());
        chk("model_level", {10'd0, level}, 12'(m_level));
        chk("model_busy", {11'd0, busy}, {11'd0, (m_white | m_fading)});
    endtask

    // One clock: drive inputs, advance model with the edge, compare 1 time unit later.
    task automatic cycle(input bit fs, input bit lu, input bit fr, input bit rs);
        frame_start = fs; level_up = lu; flash_req = fr; rst = rs;
        @(posedge clk);
        model_step(fs, lu, fr, rs);
        #1;
        check_model();
        frame_start = 0; level_up = 0; flash_req = 0; rst = 0;
    endtask

    task automatic frame(input bit lu, input bit fr);
        cycle(1, lu, fr, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(0, 0);
    endtask

    // Advance frames until the model settles, bounded so a stuck DUT cannot hang the run.
    task automatic settle(input string tag);
        for (int i = 0; i < 100 && (m_white || m_fading); i++) frame(0, 0);
        chk(tag, {11'd0, busy}, 12'd0);
    endtask

    task automatic chk_colors(input string tag, input logic [11:0] t, input logic [11:0] m);
        chk({tag, "_top"}, topColor, t);
        chk({tag, "_mid"}, midColor, m);
    endtask

    initial begin
        // Reset and quiet frames.
        cycle(0, 0, 0, 1);
        chk_colors("reset", 12'h00F, 12'h888);
        for (int i = 0; i < 3; i++) begin
            frame(0, 0);
            chk_colors("quiet", 12'h00F, 12'h888);
            chk("quiet_busy", {11'd0, busy}, 12'd0);
        end

        // Level 0 -> 1 fade.
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        chk("lvl1_level", {10'd0, level}, 12'd1);
        chk("lvl1_busy", {11'd0, busy}, 12'd1);
        cycle(0, 0, 0, 0);
        frames(2);
        chk_colors("first_step", 12'h01E, 12'h777);
        frames(27);
        chk("fade_not_done", {11'd0, busy}, 12'd1);
        frames(1);
        chk_colors("lvl1_done", 12'h0A0, 12'h444);
        chk("lvl1_done_busy", {11'd0, busy}, 12'd0);

        // Walk to level 3, then wrap to 0.
        frame(1, 0);
        settle("lvl2_settle");
        chk_colors("lvl2_done", 12'hA0A, 12'h666);
        frame(1, 0);
        settle("lvl3_settle");
        chk_colors("lvl3_done", 12'hF80, 12'h222);
        frame(1, 0);
        chk("wrap_level", {10'd0, level}, 12'd0);
        settle("wrap_settle");
        chk_colors("wrap_done", 12'h00F, 12'h888);

        // Single flash: 8 white frames.
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            frame(0, 0);
            chk_colors("flash_white", 12'hFFF, 12'hFFF);
        end
        frame(0, 0);
        chk_colors("flash_restore", 12'h00F, 12'h888);
        chk("flash_restore_busy", {11'd0, busy}, 12'd0);

        // Flash extended by a second request at flash frame 5: 13 white frames.
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 13; i++) begin
            frame(0, i == 5);
            chk_colors("flash_ext_white", 12'hFFF, 12'hFFF);
        end
        frame(0, 0);
        chk_colors("flash_ext_restore", 12'h00F, 12'h888);

        // level_up and flash_req together with frame_start: flash wins, fade follows.
        cycle(1, 1, 1, 0);
        chk_colors("prio_white", 12'hFFF, 12'hFFF);
        chk("prio_level", {10'd0, level}, 12'd0);
        cycle(0, 0, 0, 0);
        frames(8);
        chk_colors("prio_restore", 12'h00F, 12'h888);
        chk("prio_idle", {11'd0, busy}, 12'd0);
        frame(0, 0);
        chk("prio_fade_level", {10'd0, level}, 12'd1);
        chk("prio_fade_busy", {11'd0, busy}, 12'd1);

        // Reset mid-fade at 12'h05A drops everything.
        frames(10);
        chk("midfade_top", topColor, 12'h05A);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        chk_colors("rst_mid", 12'h00F, 12'h888);
        chk("rst_level", {10'd0, level}, 12'd0);
        chk("rst_busy", {11'd0, busy}, 12'd0);
        frames(2);
        chk_colors("rst_dropped", 12'h00F, 12'h888);
        chk("rst_dropped_busy", {11'd0, busy}, 12'd0);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 6000; i++)
            cycle($urandom % 4 == 0, $urandom % 25 == 0, $urandom % 60 == 0, $urandom % 2000 == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/floor_color_sequencer.md
Name: floor_color_sequencer

Overview:
Owns the colour inputs of the three-band floor renderer: drives `topColor` (top and bottom bands) and `midColor` (middle band).
- Steps through a fixed per-level palette, fading channel-by-channel between palettes when the level advances.
- Overrides both bands with a white flash on request, e.g. player death.
- All colour changes are applied only on frame boundaries so a band never changes mid-frame.

Parameters:
- NUM_LEVELS, 4, number of palette entries; level index wraps after NUM_LEVELS-1. Legal values 2..4.
- FADE_DIV, 2, frames per fade step; legal 1..15.
- FLASH_FRAMES, 8, frames the white flash is held; legal 1..15.

Ports:
- clk  input  1  system clock (pixel-clock domain)
- rst  input  1  synchronous, active-high reset
- frame_start  input  1  one-cycle pulse at start of vertical blank
- level_up  input  1  one-cycle pulse: advance to next palette
- flash_req  input  1  one-cycle pulse: start or restart white flash
- topColor  output  12  {R,G,B} 4 bits each, to top and bottom bands
- midColor  output  12  {R,G,B} 4 bits each, to middle band
- level  output  2  current target palette index
- busy  output  1  high while in FADE or FLASH

Behaviour:
- Palette (top/mid):
  - L0 = 12'h00F / 12'h888
  - L1 = 12'h0A0 / 12'h444
  - L2 = 12'hA0A / 12'h666
  - L3 = 12'hF80 / 12'h222
- Reset (sync): state=IDLE, topColor=12'h00F, midColor=12'h888, level=0, busy=0, all counters and pending flags cleared. Takes effect on the next edge regardless of state; a fade or flash in progress is abandoned.
- Request latching:
  - level_up and flash_req are latched into pend_lvl and pend_flash on any cycle.
  - Multiple level_up pulses before service collapse to one.
- Frame evaluation: the FSM evaluates only on cycles where frame_start=1. Output registers update on that edge, so outputs change 1 cycle after frame_start. A request arriving in the same cycle as frame_start is serviced at that frame.
- IDLE:
  - If pend_flash: save current colours to shadow regs, outputs=12'hFFF/12'hFFF, flash_cnt=FLASH_FRAMES-1, go FLASH.
  - Else if pend_lvl: level <= (level==NUM_LEVELS-1) ? 0 : level+1, div_cnt=FADE_DIV-1, go FADE.
  - Serviced pend bits clear.
  - flash_req has priority over level_up; a level_up left unserviced stays pending.
- FADE, per frame_start:
  - If div_cnt≠0: decrement.
  - Else: reload div_cnt=FADE_DIV-1 and move every 4-bit channel of both outputs one step (±1, unsigned, no wrap) toward the palette entry for `level`. Channels already equal are untouched.
  - When both outputs equal target after the step, go IDLE.
  - Worst case is 15*FADE_DIV frames.
  - pend_flash in FADE: enter FLASH as from IDLE. Shadow regs hold the partial-fade colours; FADE resumes from them afterwards.
  - pend_lvl in FADE: stays pending, serviced once IDLE is reached.
- FLASH, per frame_start:
  - pend_flash: reload flash_cnt=FLASH_FRAMES-1 and clear it.
  - Else if flash_cnt≠0: decrement.
  - Else: restore outputs from shadow regs. Go FADE if shadow≠target palette, else IDLE.
  - level does not change while in FLASH.
- busy = (state≠IDLE), registered.
- Outputs hold between frame_start pulses; no combinational path from inputs to outputs.

Test Plan:
1. Reset then 3 frame_starts, no requests -> topColor=12'h00F, midColor=12'h888, level=0, busy=0 throughout.
2. FADE_DIV=2; level_up, then frame_starts -> level=1 and busy=1 one cycle after the 1st frame_start.
   - After 2 further frames: topColor=12'h01E, midColor=12'h777.
   - After 30 frames: topColor=12'h0A0, midColor=12'h444, busy=0.
3. Level wrap: at level=3 (colours 12'hF80/12'h222), level_up -> level=0; fade ends at 12'h00F/12'h888.
4. flash_req in IDLE at L0 -> 12'hFFF/12'hFFF from 1 cycle after next frame_start for 8 frames, then 12'h00F/12'h888, busy=0.
   - A second flash_req at flash frame 5 extends white to 13 frames total.
5. level_up and flash_req in the same cycle as frame_start -> FLASH first (level stays 0); after flash, FADE to L1 begins at next frame_start.
6. rst asserted mid-FADE (topColor=12'h05A) -> next cycle 12'h00F/12'h888, level=0, busy=0, pending requests dropped.
